// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI master datapath.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } spi_state_e;

  localparam int SPI_DIV_WIDTH = 16;
  localparam int SPI_LEN_WIDTH = 8;

endpackage

// File: rtl/dffr.sv
// Common flop cell: asynchronous active-low reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) q_o <= '0;
    else          q_o <= d_i;
  end

endmodule

// File: rtl/dffre.sv
// Common flop cell with load enable: asynchronous active-low reset to zero.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/spi_sck_gen.sv
// SPI serial-clock generator: bounded transfer of len+1 bits, all CPOL/CPHA modes,
// with per-edge rise/fall/sample/shift strobes for the shift register.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = SPI_DIV_WIDTH,
  parameter int LEN_WIDTH = SPI_LEN_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic                 sck_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 sample_o,
  output logic                 shift_o,
  output logic                 busy_o,
  output logic                 done_o,
  output spi_state_e           state_o
);

  // One extra bit so 2*(len+1) edges fit even at the maximum len.
  localparam int CNT_WIDTH = LEN_WIDTH + 1;

  logic                 r_state_bit;
  spi_state_e           w_state;
  spi_state_e           w_state_d;
  logic [DIV_WIDTH-1:0] r_div;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_cpol;
  logic                 r_cpha;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [DIV_WIDTH-1:0] w_div_cnt_d;
  logic [CNT_WIDTH-1:0] r_edge_cnt;
  logic [CNT_WIDTH-1:0] w_edge_cnt_d;
  logic                 r_sck;
  logic                 w_sck_d;
  logic                 r_done;
  logic                 w_done_d;
  logic                 w_run;
  logic                 w_start;
  logic                 w_event;
  logic                 w_last;
  logic                 w_leading;
  logic                 w_strobe;

  assign w_state = r_state_bit ? RUN : IDLE;
  assign w_run   = (w_state == RUN);
  assign w_start = (w_state == IDLE) & start_i;

  // Edge counter holds the number of edges already taken, so an even value
  // means the upcoming edge is a leading one.
  assign w_event   = w_run & (r_div_cnt == r_div);
  assign w_last    = w_event & (r_edge_cnt == {r_len, 1'b1});
  assign w_leading = ~r_edge_cnt[0];
  assign w_strobe  = w_event & ~stop_i;

  assign rise_o   = w_strobe & ~r_sck;
  assign fall_o   = w_strobe & r_sck;
  assign sample_o = w_strobe & (r_cpha ? ~w_leading : w_leading);
  assign shift_o  = w_strobe & (r_cpha ? w_leading : (~w_leading & ~w_last));
  assign busy_o   = w_run;
  assign done_o   = r_done;
  assign sck_o    = r_sck;
  assign state_o  = w_state;

  always_comb begin
    w_state_d    = w_state;
    w_div_cnt_d  = '0;
    w_edge_cnt_d = '0;
    w_sck_d      = r_sck;
    w_done_d     = 1'b0;
    case (w_state)
      IDLE: begin
        w_sck_d = cpol_i;
        if (start_i) w_state_d = RUN;
      end
      RUN: begin
        if (stop_i) begin
          w_state_d = IDLE;
          w_sck_d   = r_cpol;
        end else if (w_last) begin
          w_state_d = IDLE;
          w_sck_d   = r_cpol;
          w_done_d  = 1'b1;
        end else if (w_event) begin
          w_sck_d      = ~r_sck;
          w_edge_cnt_d = r_edge_cnt + 1'b1;
        end else begin
          w_div_cnt_d  = r_div_cnt + 1'b1;
          w_edge_cnt_d = r_edge_cnt;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  dffr #(.W(1)) u_state (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (w_state_d == RUN),
    .q_o     (r_state_bit)
  );

  dffr #(.W(DIV_WIDTH)) u_div_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (w_div_cnt_d),
    .q_o     (r_div_cnt)
  );

  dffr #(.W(CNT_WIDTH)) u_edge_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (w_edge_cnt_d),
    .q_o     (r_edge_cnt)
  );

  dffr #(.W(1)) u_sck (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (w_sck_d),
    .q_o     (r_sck)
  );

  dffr #(.W(1)) u_done (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (w_done_d),
    .q_o     (r_done)
  );

  // Configuration is frozen at start so mid-transfer input changes are ignored.
  dffre #(.W(DIV_WIDTH)) u_div (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_start),
    .d_i     (div_i),
    .q_o     (r_div)
  );

  dffre #(.W(LEN_WIDTH)) u_len (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_start),
    .d_i     (len_i),
    .q_o     (r_len)
  );

  dffre #(.W(1)) u_cpol (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_start),
    .d_i     (cpol_i),
    .q_o     (r_cpol)
  );

  dffre #(.W(1)) u_cpha (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_start),
    .d_i     (cpha_i),
    .q_o     (r_cpha)
  );

endmodule
